// File: rtl/auth_seq_ctrl.sv
// -----------------------------------------------------------------------------
// auth_seq_ctrl
//
// PIN-gated power authorisation controller. Bytes from uart_rx are consumed
// every cycle they are offered. In OFF, a PIN_LEN-byte PIN (most significant
// byte first) followed by GO_CODE, with the rider present, powers up. In
// PWR_ON, STOP_CODE arms a debounced power-down. The power-down fires after
// OFF_DLY consecutive rider_off cycles; a GO in the armed state cancels it.
// MAX_FAIL failed attempts lock the controller out for LOCK_CYC cycles.
//
// Ports:
//   i_clk         system clock
//   i_rst         synchronous, active-high reset
//   i_rx_data     byte from uart_rx
//   i_rx_rdy      byte valid from uart_rx
//   i_rider_off   rider-not-present indication
//   o_clr_rx_rdy  byte consumed, clears uart_rx rdy (combinational)
//   o_pwr_up      power enable (PWR_ON or STOP_ARMED)
//   o_locked      high while in LOCKOUT
//   o_auth_fail   one-cycle pulse per failed attempt
// -----------------------------------------------------------------------------
module auth_seq_ctrl #(
    parameter int          PIN_LEN   = 2,
    parameter logic [31:0] PIN       = 32'h0000_3134,
    parameter logic [7:0]  GO_CODE   = 8'h67,
    parameter logic [7:0]  STOP_CODE = 8'h73,
    parameter int          OFF_DLY   = 1024,
    parameter int          MAX_FAIL  = 3,
    parameter int          LOCK_CYC  = 4096
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [7:0] i_rx_data,
    input  logic       i_rx_rdy,
    input  logic       i_rider_off,
    output logic       o_clr_rx_rdy,
    output logic       o_pwr_up,
    output logic       o_locked,
    output logic       o_auth_fail
);

    localparam int PIDX_W = $clog2(PIN_LEN + 1);
    localparam int FAIL_W = $clog2(MAX_FAIL + 1);
    localparam int DLY_W  = $clog2(OFF_DLY + 1);
    localparam int LOCK_W = $clog2(LOCK_CYC + 1);

    localparam logic [PIDX_W-1:0] PIN_LEN_C = PIDX_W'(PIN_LEN);
    localparam logic [FAIL_W-1:0] FAIL_MAX  = FAIL_W'(MAX_FAIL);
    localparam logic [DLY_W-1:0]  DLY_LAST  = DLY_W'(OFF_DLY - 1);
    localparam logic [DLY_W-1:0]  DLY_MAX   = DLY_W'(OFF_DLY);
    localparam logic [LOCK_W-1:0] LOCK_LAST = LOCK_W'(LOCK_CYC - 1);
    localparam logic [LOCK_W-1:0] LOCK_MAX  = LOCK_W'(LOCK_CYC);

    typedef enum logic [1:0] {
        S_OFF        = 2'd0,
        S_PWR_ON     = 2'd1,
        S_STOP_ARMED = 2'd2,
        S_LOCKOUT    = 2'd3
    } state_t;

    state_t              r_state;
    logic [PIDX_W-1:0]   r_pin_idx;
    logic [FAIL_W-1:0]   r_fail_cnt;
    logic [DLY_W-1:0]    r_dly_cnt;
    logic [LOCK_W-1:0]   r_lock_cnt;
    logic                r_auth_fail;

    state_t              w_state_nxt;
    logic [PIDX_W-1:0]   w_pin_idx_nxt;
    logic [FAIL_W-1:0]   w_fail_cnt_nxt;
    logic [DLY_W-1:0]    w_dly_cnt_nxt;
    logic [LOCK_W-1:0]   w_lock_cnt_nxt;
    logic                w_auth_fail_nxt;

    logic                w_accept;
    logic [7:0]          w_exp_byte;
    logic [FAIL_W-1:0]   w_fail_inc;

    // A byte is never stalled: it is consumed whenever offered outside reset.
    assign w_accept     = i_rx_rdy & ~i_rst;
    assign o_clr_rx_rdy = w_accept;

    assign o_pwr_up    = (r_state == S_PWR_ON) || (r_state == S_STOP_ARMED);
    assign o_locked    = (r_state == S_LOCKOUT);
    assign o_auth_fail = r_auth_fail;

    // Expected PIN byte: index 0 of the sequence is the most significant byte.
    always_comb begin
        w_exp_byte = 8'h00;
        for (int k = 0; k < PIN_LEN; k++) begin
            if (r_pin_idx == PIDX_W'(k)) begin
                w_exp_byte = PIN[(PIN_LEN-1-k)*8 +: 8];
            end
        end
    end

    assign w_fail_inc = (r_fail_cnt == FAIL_MAX) ? r_fail_cnt : r_fail_cnt + 1'b1;

    always_comb begin
        w_state_nxt     = r_state;
        w_pin_idx_nxt   = r_pin_idx;
        w_fail_cnt_nxt  = r_fail_cnt;
        w_dly_cnt_nxt   = r_dly_cnt;
        w_lock_cnt_nxt  = r_lock_cnt;
        w_auth_fail_nxt = 1'b0;

        case (r_state)
            S_OFF: begin
                if (w_accept) begin
                    if ((r_pin_idx < PIN_LEN_C) && (i_rx_data == w_exp_byte)) begin
                        w_pin_idx_nxt = r_pin_idx + 1'b1;
                    end else if ((r_pin_idx == PIN_LEN_C) && (i_rx_data == GO_CODE)) begin
                        // GO with the rider absent discards the PIN but is
                        // not counted as a failed attempt.
                        w_pin_idx_nxt = '0;
                        if (!i_rider_off) begin
                            w_state_nxt    = S_PWR_ON;
                            w_fail_cnt_nxt = '0;
                        end
                    end else begin
                        // The failing byte restarts the PIN; it is not itself
                        // re-examined as a possible first PIN byte.
                        w_pin_idx_nxt   = '0;
                        w_fail_cnt_nxt  = w_fail_inc;
                        w_auth_fail_nxt = 1'b1;
                        if (w_fail_inc == FAIL_MAX) begin
                            w_state_nxt    = S_LOCKOUT;
                            w_lock_cnt_nxt = '0;
                        end
                    end
                end
            end

            S_LOCKOUT: begin
                if (r_lock_cnt == LOCK_LAST) begin
                    w_state_nxt    = S_OFF;
                    w_fail_cnt_nxt = '0;
                    w_pin_idx_nxt  = '0;
                end else if (r_lock_cnt != LOCK_MAX) begin
                    w_lock_cnt_nxt = r_lock_cnt + 1'b1;
                end
            end

            S_PWR_ON: begin
                if (w_accept && (i_rx_data == STOP_CODE)) begin
                    w_state_nxt   = S_STOP_ARMED;
                    w_dly_cnt_nxt = '0;
                end
            end

            S_STOP_ARMED: begin
                // GO takes priority over a simultaneous debounce expiry.
                if (w_accept && (i_rx_data == GO_CODE)) begin
                    w_state_nxt = S_PWR_ON;
                end else if (i_rider_off) begin
                    if (r_dly_cnt == DLY_LAST) begin
                        w_state_nxt   = S_OFF;
                        w_pin_idx_nxt = '0;
                    end else if (r_dly_cnt != DLY_MAX) begin
                        w_dly_cnt_nxt = r_dly_cnt + 1'b1;
                    end
                end else begin
                    w_dly_cnt_nxt = '0;
                end
            end

            default: begin
                w_state_nxt   = S_OFF;
                w_pin_idx_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= S_OFF;
            r_pin_idx   <= '0;
            r_fail_cnt  <= '0;
            r_dly_cnt   <= '0;
            r_lock_cnt  <= '0;
            r_auth_fail <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_pin_idx   <= w_pin_idx_nxt;
            r_fail_cnt  <= w_fail_cnt_nxt;
            r_dly_cnt   <= w_dly_cnt_nxt;
            r_lock_cnt  <= w_lock_cnt_nxt;
            r_auth_fail <= w_auth_fail_nxt;
        end
    end

endmodule

// File: tb/tb_auth_seq_ctrl.sv
module tb_auth_seq_ctrl;

    localparam int          PIN_LEN  = 2;
    localparam logic [31:0] PIN_V    = 32'h0000_3134;
    localparam logic [7:0]  GO       = 8'h67;
    localparam logic [7:0]  STOP     = 8'h73;
    localparam int          OFF_DLY  = 8;
    localparam int          MAX_FAIL = 3;
    localparam int          LOCK_CYC = 20;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rdy = 1'b0;
    logic       roff = 1'b0;
    logic [7:0] data = 8'h00;
    logic       clr, pwr, lck, af;

    always #5 clk = ~clk;

    auth_seq_ctrl #(
        .PIN_LEN(PIN_LEN), .PIN(PIN_V), .GO_CODE(GO), .STOP_CODE(STOP),
        .OFF_DLY(OFF_DLY), .MAX_FAIL(MAX_FAIL), .LOCK_CYC(LOCK_CYC)
    ) dut (
        .i_clk(clk), .i_rst(rst), .i_rx_data(data), .i_rx_rdy(rdy),
        .i_rider_off(roff), .o_clr_rx_rdy(clr), .o_pwr_up(pwr),
        .o_locked(lck), .o_auth_fail(af)
    );

    int checks = 0;
    int failures = 0;

    typedef struct packed {
        logic       r;
        logic       v;
        logic [7:0] d;
        logic       o;
    } stim_t;

    stim_t q[$];

    // Reference model: powered flag, stop request, length of the current
    // rider-off run, lockout cycles remaining, PIN bytes matched so far.
    bit m_on, m_stop, m_pulse;
    int m_run, m_lock, m_got, m_fails;

    function automatic logic [7:0] pin_byte(int i);
        logic [31:0] p;
        p = PIN_V >> (8 * (PIN_LEN - 1 - i));
        return p[7:0];
    endfunction

    function automatic void model_clear();
        m_on = 0; m_stop = 0; m_pulse = 0;
        m_run = 0; m_lock = 0; m_got = 0; m_fails = 0;
    endfunction

    function automatic void model_step(stim_t s);
        if (s.r) begin
            model_clear();
            return;
        end
        m_pulse = 0;
        if (m_lock > 0) begin
            m_lock--;
            if (m_lock == 0) begin
                m_fails = 0;
                m_got = 0;
            end
        end else if (m_on) begin
            if (!m_stop) begin
                if (s.v && s.d == STOP) begin
                    m_stop = 1;
                    m_run = 0;
                end
            end else if (s.v && s.d == GO) begin
                m_stop = 0;
            end else if (s.o) begin
                m_run++;
                if (m_run >= OFF_DLY) begin
                    m_on = 0; m_stop = 0; m_got = 0;
                end
            end else begin
                m_run = 0;
            end
        end else if (s.v) begin
            if (m_got < PIN_LEN && s.d == pin_byte(m_got)) begin
                m_got++;
            end else if (m_got == PIN_LEN && s.d == GO) begin
                m_got = 0;
                if (!s.o) begin
                    m_on = 1; m_stop = 0; m_fails = 0;
                end
            end else begin
                m_got = 0;
                m_fails++;
                m_pulse = 1;
                if (m_fails >= MAX_FAIL) m_lock = LOCK_CYC;
            end
        end
    endfunction

    function automatic logic [3:0] model_out(stim_t s);
        return {s.v & ~s.r, m_on, (m_lock > 0), m_pulse};
    endfunction

    function automatic void add(logic r, logic v, logic [7:0] d, logic o);
        q.push_back('{r: r, v: v, d: d, o: o});
    endfunction

    function automatic void add_idle(int n, logic o);
        for (int i = 0; i < n; i++) add(1'b0, 1'b0, 8'($urandom), o);
    endfunction

    // Byte followed by one idle cycle: upstream drops rdy after clr.
    function automatic void add_byte(logic [7:0] d, logic o);
        add(1'b0, 1'b1, d, o);
        add_idle(1, o);
    endfunction

    function automatic void add_unlock();
        add_byte(8'h31, 1'b0);
        add_byte(8'h34, 1'b0);
        add_byte(GO, 1'b0);
    endfunction

    task automatic drive(stim_t s);
        rst = s.r; rdy = s.v; data = s.d; roff = s.o;
        @(negedge clk);
    endtask

    task automatic advance(stim_t s);
        @(posedge clk);
        model_step(s);
        #1;
    endtask

    task automatic test_reset();
        stim_t s;
        s = '{r: 1'b1, v: 1'b1, d: GO, o: 1'b0};
        model_clear();
        drive(s);
        advance(s);
        q.delete();
        add(1'b1, 1'b1, 8'h31, 1'b0);
        add_idle(3, 1'b0);
        foreach (q[i]) begin
            drive(q[i]);
            checks++;
            if ({clr, pwr, lck, af} !== model_out(q[i])) begin
                failures++;
                $display("FAIL reset step=%0d got=%b exp=%b", i, {clr, pwr, lck, af}, model_out(q[i]));
            end
            advance(q[i]);
        end
    endtask

    task automatic test_unlock();
        int af_cnt = 0;
        q.delete();
        add(1'b1, 1'b0, 8'h00, 1'b0);
        add_unlock();
        add_idle(2, 1'b0);
        foreach (q[i]) begin
            drive(q[i]);
            checks++;
            if ({clr, pwr, lck, af} !== model_out(q[i])) begin
                failures++;
                $display("FAIL unlock step=%0d got=%b exp=%b", i, {clr, pwr, lck, af}, model_out(q[i]));
            end
            af_cnt += int'(af);
            advance(q[i]);
        end
        checks++;
        if (pwr !== 1'b1) begin
            failures++;
            $display("FAIL unlock_pwr got=%b exp=1", pwr);
        end
        checks++;
        if (af_cnt != 0) begin
            failures++;
            $display("FAIL unlock_no_fail got=%0d exp=0", af_cnt);
        end
    endtask

    task automatic test_lockout();
        int af_cnt = 0;
        int lk_cnt = 0;
        q.delete();
        add(1'b1, 1'b0, 8'h00, 1'b0);
        add_byte(8'h31, 1'b0);
        add_byte(8'h35, 1'b0);
        add_byte(8'h32, 1'b0);
        add_byte(GO, 1'b0);
        add_byte(8'h31, 1'b0);
        add_byte(8'h34, 1'b0);
        add_byte(GO, 1'b0);
        add_idle(20, 1'b0);
        foreach (q[i]) begin
            drive(q[i]);
            checks++;
            if ({clr, pwr, lck, af} !== model_out(q[i])) begin
                failures++;
                $display("FAIL lockout step=%0d got=%b exp=%b", i, {clr, pwr, lck, af}, model_out(q[i]));
            end
            af_cnt += int'(af);
            lk_cnt += int'(lck);
            advance(q[i]);
        end
        checks++;
        if (af_cnt != 3) begin
            failures++;
            $display("FAIL lockout_pulses got=%0d exp=3", af_cnt);
        end
        checks++;
        if (lk_cnt != LOCK_CYC) begin
            failures++;
            $display("FAIL lockout_len got=%0d exp=%0d", lk_cnt, LOCK_CYC);
        end
        q.delete();
        add_unlock();
        foreach (q[i]) begin
            drive(q[i]);
            checks++;
            if ({clr, pwr, lck, af} !== model_out(q[i])) begin
                failures++;
                $display("FAIL post_lock step=%0d got=%b exp=%b", i, {clr, pwr, lck, af}, model_out(q[i]));
            end
            advance(q[i]);
        end
        checks++;
        if (pwr !== 1'b1) begin
            failures++;
            $display("FAIL post_lock_pwr got=%b exp=1", pwr);
        end
    endtask

    task automatic test_rider_off_go();
        int af_cnt = 0;
        q.delete();
        add(1'b1, 1'b0, 8'h00, 1'b0);
        add_byte(8'h31, 1'b1);
        add_byte(8'h34, 1'b1);
        add_byte(GO, 1'b1);
        foreach (q[i]) begin
            drive(q[i]);
            checks++;
            if ({clr, pwr, lck, af} !== model_out(q[i])) begin
                failures++;
                $display("FAIL roff_go step=%0d got=%b exp=%b", i, {clr, pwr, lck, af}, model_out(q[i]));
            end
            af_cnt += int'(af);
            advance(q[i]);
        end
        checks++;
        if (pwr !== 1'b0 || af_cnt != 0) begin
            failures++;
            $display("FAIL roff_go_held got pwr=%b fails=%0d exp pwr=0 fails=0", pwr, af_cnt);
        end
        q.delete();
        add_unlock();
        foreach (q[i]) begin
            drive(q[i]);
            advance(q[i]);
        end
        checks++;
        if (pwr !== 1'b1) begin
            failures++;
            $display("FAIL roff_go_retry got=%b exp=1", pwr);
        end
    endtask

    task automatic test_stop_debounce();
        q.delete();
        add(1'b1, 1'b0, 8'h00, 1'b0);
        add_unlock();
        add_idle(12, 1'b1);
        add(1'b0, 1'b1, STOP, 1'b0);
        add_idle(5, 1'b1);
        add_idle(1, 1'b0);
        add_idle(7, 1'b1);
        foreach (q[i]) begin
            drive(q[i]);
            checks++;
            if ({clr, pwr, lck, af} !== model_out(q[i])) begin
                failures++;
                $display("FAIL debounce step=%0d got=%b exp=%b", i, {clr, pwr, lck, af}, model_out(q[i]));
            end
            advance(q[i]);
        end
        checks++;
        if (pwr !== 1'b1) begin
            failures++;
            $display("FAIL debounce_hold got=%b exp=1", pwr);
        end
        q.delete();
        add_idle(1, 1'b1);
        add_idle(2, 1'b0);
        foreach (q[i]) begin
            drive(q[i]);
            advance(q[i]);
        end
        checks++;
        if (pwr !== 1'b0) begin
            failures++;
            $display("FAIL debounce_off got=%b exp=0", pwr);
        end
    endtask

    task automatic test_cancel_race();
        q.delete();
        add(1'b1, 1'b0, 8'h00, 1'b0);
        add_unlock();
        add(1'b0, 1'b1, STOP, 1'b0);
        add_idle(7, 1'b1);
        add(1'b0, 1'b1, GO, 1'b1);
        add_idle(10, 1'b1);
        foreach (q[i]) begin
            drive(q[i]);
            checks++;
            if ({clr, pwr, lck, af} !== model_out(q[i])) begin
                failures++;
                $display("FAIL race step=%0d got=%b exp=%b", i, {clr, pwr, lck, af}, model_out(q[i]));
            end
            advance(q[i]);
        end
        checks++;
        if (pwr !== 1'b1) begin
            failures++;
            $display("FAIL race_pwr got=%b exp=1", pwr);
        end
    endtask

    task automatic test_reset_mid();
        q.delete();
        add(1'b1, 1'b0, 8'h00, 1'b0);
        add_unlock();
        add(1'b1, 1'b1, GO, 1'b0);
        foreach (q[i]) begin
            drive(q[i]);
            checks++;
            if ({clr, pwr, lck, af} !== model_out(q[i])) begin
                failures++;
                $display("FAIL rst_mid step=%0d got=%b exp=%b", i, {clr, pwr, lck, af}, model_out(q[i]));
            end
            advance(q[i]);
        end
        checks++;
        if (pwr !== 1'b0 || lck !== 1'b0) begin
            failures++;
            $display("FAIL rst_mid_out got pwr=%b locked=%b exp 0 0", pwr, lck);
        end
        q.delete();
        add_byte(GO, 1'b0);
        foreach (q[i]) begin
            drive(q[i]);
            advance(q[i]);
        end
        checks++;
        if (pwr !== 1'b0) begin
            failures++;
            $display("FAIL rst_mid_pin_needed got=%b exp=0", pwr);
        end
    endtask

    task automatic test_random();
        logic o = 1'b0;
        logic prev_v = 1'b0;
        logic [7:0] d;
        logic v, r;
        q.delete();
        add(1'b1, 1'b0, 8'h00, 1'b0);
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 9) == 0) o = ~o;
            case ($urandom_range(0, 5))
                0, 1:    d = 8'h31;
                2:       d = 8'h34;
                3:       d = GO;
                4:       d = STOP;
                default: d = 8'($urandom);
            endcase
            v = !prev_v && ($urandom_range(0, 2) == 0);
            r = ($urandom_range(0, 299) == 0);
            add(r, v, d, o);
            prev_v = v;
        end
        foreach (q[i]) begin
            drive(q[i]);
            checks++;
            if ({clr, pwr, lck, af} !== model_out(q[i])) begin
                failures++;
                $display("FAIL random step=%0d got=%b exp=%b", i, {clr, pwr, lck, af}, model_out(q[i]));
            end
            advance(q[i]);
        end
    endtask

    initial begin
        test_reset();
        test_unlock();
        test_lockout();
        test_rider_off_go();
        test_stop_debounce();
        test_cancel_race();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
